pipe_arb: RTL and testbench
===========================

PIPE_ARB -- requirements
Module: pipe_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 8: payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: fixed latency, in cycles, of the shared pipe.
REQ-003 SHALL have parameter NREQ, default 4: number of requesters.
REQ-004 SHALL have parameter MAX_OUT, default 2: maximum in-flight transactions per requester, 1..DEPTH.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports:
- req  in  NREQ  per-requester issue request.
- req_data  in  NREQ*WIDTH  payload; requester i occupies slice [i*WIDTH +: WIDTH].
- gnt  out  NREQ  one-hot grant, combinational; issue occurs when req[i] and gnt[i] are both high.
- pipe_valid_in  out  1  valid to the pipe, equal to OR of gnt.
- pipe_data_in  out  WIDTH  req_data slice of the granted requester; 0 when idle.
- pipe_valid_out  in  1  valid from the pipe.
- pipe_data_out  in  WIDTH  data from the pipe.
- rsp_valid  out  NREQ  one-hot response strobe, combinational from pipe_valid_out.
- rsp_data  out  WIDTH  equal to pipe_data_out.
- flush_req  in  1  pulse that starts a drain.
- flush_done  out  1  registered, one-cycle pulse at drain completion.
- busy  out  1  high when the in-flight count is nonzero or state is not IDLE.
- err  out  1  sticky protocol-error flag.

Function
REQ-007 SHALL keep a 3-state FSM: IDLE, RUN, DRAIN.
- IDLE -> RUN on any req.
- RUN -> IDLE when req is 0 and in-flight is 0.
- Any state -> DRAIN on flush_req.
- DRAIN -> IDLE when in-flight is 0; flush_done pulses in the cycle after entering IDLE.
REQ-008 SHALL drive gnt to 0 in IDLE and in DRAIN, including the first cycle flush_req is seen.
REQ-009 SHALL treat requester i as eligible when req[i] is high and outstanding[i] < MAX_OUT.
REQ-010 SHALL grant, in RUN, the first eligible requester found at or after rr_ptr, searching upward modulo NREQ.
REQ-011 SHALL set rr_ptr to (i+1) mod NREQ after a grant to requester i, and leave it unchanged otherwise.
REQ-012 SHALL keep a DEPTH-stage tag shift register, holding {valid, requester id} per stage, that advances every cycle in step with the pipe.
- Stage 0 loads {pipe_valid_in, granted id}.
REQ-013 SHALL drive rsp_valid[id] high when pipe_valid_out is high, where id is the tag at stage DEPTH-1.
REQ-014 SHALL keep per-requester outstanding counters, ceil(log2(MAX_OUT+1)) bits each.
- +1 on issue; -1 on response.
- Issue and response for the same requester in the same cycle: no change.
REQ-015 SHALL keep an in-flight counter of 0..DEPTH with the same +1 / -1 / hold rules.
REQ-016 SHALL set err, held until reset, on any of:
- pipe_valid_out differs from the stage DEPTH-1 tag valid;
- decrement of a zero counter;
- increment past the limit.
REQ-017 SHALL never overflow: no requester exceeds MAX_OUT, and the in-flight count never exceeds DEPTH.
REQ-018 SHALL ignore flush_req while already in DRAIN.
- flush_req in IDLE with in-flight 0 goes to DRAIN, then IDLE the next cycle, and flush_done pulses.

Reset
REQ-019 SHALL, while reset_n is low, force:
- FSM = IDLE; rr_ptr = 0;
- all counters and tag stages = 0;
- err, flush_done = 0.
REQ-020 SHALL drive gnt, pipe_valid_in, pipe_data_in, rsp_valid, busy to 0 while reset_n is low.
REQ-021 SHALL, on reset_n assertion mid-operation, drop in-flight tags silently.
- The integrator holds the pipe's own synchronous reset for at least one clk edge during that reset.

Verification
REQ-022 Single requester, DEPTH=4:
- req[2]=1 with data 0x5A for one cycle -> gnt=0100 that cycle.
- Four cycles later: rsp_valid=0100, rsp_data=0x5A; outstanding[2] returns to 0.
REQ-023 Round robin:
- req=1111 held for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3.
- With MAX_OUT=2, no requester is blocked.
REQ-024 Credit limit, MAX_OUT=1:
- req=0001 held -> gnt[0] every 4th cycle only.
- Each issue coincides with the preceding response, and the counter never exceeds 1.
REQ-025 Drain:
- flush_req with 3 in flight -> gnt=0 immediately, busy=1.
- flush_done pulses exactly one cycle after the last response; err stays 0.
REQ-026 Protocol error:
- Inject pipe_valid_out=1 with the tag pipe empty -> err=1 next cycle, held until reset_n is low.
REQ-027 Async reset mid-stream:
- reset_n low between clock edges with 4 in flight -> all outputs 0 immediately, with no rsp_valid after release.

Source files
------------

// File: rtl/pipe_arb.sv
// Round-robin arbiter feeding a fixed-latency shared pipe, with per-requester
// credit limits, response routing by tag shift register, drain control and error flag.
module pipe_arb #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int NREQ    = 4,
  parameter int MAX_OUT = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic                  pipe_valid_in,
  output logic [WIDTH-1:0]      pipe_data_in,
  input  logic                  pipe_valid_out,
  input  logic [WIDTH-1:0]      pipe_data_out,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic                  busy,
  output logic                  err
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(MAX_OUT + 1);
  localparam int FW  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state, state_d;
  logic [IDW-1:0]  rr_ptr;
  logic [CW-1:0]   outstanding   [NREQ];
  logic [CW-1:0]   outstanding_d [NREQ];
  logic [FW-1:0]   inflight, inflight_d;
  logic            tag_v  [DEPTH];
  logic [IDW-1:0]  tag_id [DEPTH];

  logic            rsp, can_grant, found, err_set;
  logic [NREQ-1:0] elig;
  logic [IDW-1:0]  gnt_id;

  // Responses are steered by the tag that entered the pipe alongside the payload.
  always_comb begin
    rsp = pipe_valid_out && reset_n;
    for (int i = 0; i < NREQ; i++)
      rsp_valid[i] = rsp && (tag_id[DEPTH-1] == IDW'(i));
  end

  assign rsp_data = pipe_data_out;

  // A response returning this cycle frees its credit, so issue can overlap it.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    found        = 1'b0;
    gnt_id       = '0;
    gnt          = '0;
    pipe_data_in = '0;
    for (int i = 0; i < NREQ; i++)
      elig[i] = req[i] && ((outstanding[i] < CW'(MAX_OUT)) || rsp_valid[i]);
    can_grant = (state == RUN) && !flush_req && ((inflight < FW'(DEPTH)) || rsp);
    for (int i = 0; i < NREQ; i++)
      if (!found && elig[i] && (IDW'(i) >= rr_ptr)) begin
        found  = 1'b1;
        gnt_id = IDW'(i);
      end
    for (int i = 0; i < NREQ; i++)
      if (!found && elig[i]) begin
        found  = 1'b1;
        gnt_id = IDW'(i);
      end
    if (can_grant && found)
      gnt = NREQ'(1) << gnt_id;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) pipe_data_in = req_data[i*WIDTH +: WIDTH];
  end

  assign pipe_valid_in = |gnt;

  always_comb begin
    err_set    = (rsp != tag_v[DEPTH-1]);
    inflight_d = inflight;
    for (int i = 0; i < NREQ; i++) begin
      outstanding_d[i] = outstanding[i];
      case ({gnt[i], rsp_valid[i]})
        2'b10:   if (outstanding[i] == CW'(MAX_OUT)) err_set = 1'b1;
                 else outstanding_d[i] = outstanding[i] + 1'b1;
        2'b01:   if (outstanding[i] == '0) err_set = 1'b1;
                 else outstanding_d[i] = outstanding[i] - 1'b1;
        default: ;
      endcase
    end
    case ({pipe_valid_in, rsp})
      2'b10:   if (inflight == FW'(DEPTH)) err_set = 1'b1;
               else inflight_d = inflight + 1'b1;
      2'b01:   if (inflight == '0) err_set = 1'b1;
               else inflight_d = inflight - 1'b1;
      default: ;
    endcase
  end

  // Drain exits once the last response has been accounted for this cycle.
  always_comb begin
    state_d = state;
    if (flush_req && (state != DRAIN))
      state_d = DRAIN;
    else
      case (state)
        IDLE:    if (|req) state_d = RUN;
        RUN:     if ((req == '0) && (inflight == '0)) state_d = IDLE;
        DRAIN:   if (inflight_d == '0) state_d = IDLE;
        default: state_d = IDLE;
      endcase
  end

  assign busy = (inflight != '0) || (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      inflight   <= '0;
      err        <= 1'b0;
      flush_done <= 1'b0;
      for (int i = 0; i < NREQ; i++) outstanding[i] <= '0;
      // NOTE: the tag stages are control state, so they are cleared like any flop;
      // a reset mid-stream therefore discards in-flight tags.
      for (int s = 0; s < DEPTH; s++) begin
        tag_v[s]  <= 1'b0;
        tag_id[s] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state      <= state_d;
      inflight   <= inflight_d;
      err        <= err | err_set;
      flush_done <= (state == DRAIN) && (state_d == IDLE);
      for (int i = 0; i < NREQ; i++) outstanding[i] <= outstanding_d[i];
      if (pipe_valid_in)
        rr_ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
      tag_v[0]  <= pipe_valid_in;
      tag_id[0] <= pipe_valid_in ? gnt_id : '0;
      for (int s = 1; s < DEPTH; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

endmodule

// File: tb/tb_pipe_arb.sv
// Bench for pipe_arb: vector table plus response scoreboard on a MAX_OUT=2 instance,
// and a MAX_OUT=1 instance for the credit-limit sequence.
module tb_pipe_arb;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int NREQ  = 4;

  logic                clk = 1'b0;
  logic                reset_n = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*W-1:0]   req_data = '0;
  logic                flush_req = 1'b0;
  logic                inject = 1'b0;

  logic [NREQ-1:0]     gnt_a, rsp_valid_a, gnt_b, rsp_valid_b;
  logic                pvi_a, pvi_b, pvo_a, pvo_b;
  logic [W-1:0]        pdi_a, pdi_b, rsp_data_a, rsp_data_b;
  logic                fd_a, fd_b, busy_a, busy_b, err_a, err_b;

  logic                pv_a [DEPTH];
  logic                pv_b [DEPTH];
  logic [W-1:0]        pd_a [DEPTH];
  logic [W-1:0]        pd_b [DEPTH];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit sb_on   = 1'b1;

  typedef struct {
    int              due;
    logic [NREQ-1:0] rsp;
    logic [W-1:0]    data;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    bit              rst;
    logic [NREQ-1:0] req;
    logic [NREQ*W-1:0] data;
    bit              flush;
    logic [NREQ-1:0] gnt;
    logic [W-1:0]    pdata;
    bit              busy;
    bit              fd;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_arb #(.WIDTH(W), .DEPTH(DEPTH), .NREQ(NREQ), .MAX_OUT(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
    .gnt(gnt_a), .pipe_valid_in(pvi_a), .pipe_data_in(pdi_a),
    .pipe_valid_out(pvo_a), .pipe_data_out(pd_a[DEPTH-1]),
    .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .flush_req(flush_req),
    .flush_done(fd_a), .busy(busy_a), .err(err_a));

  pipe_arb #(.WIDTH(W), .DEPTH(DEPTH), .NREQ(NREQ), .MAX_OUT(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
    .gnt(gnt_b), .pipe_valid_in(pvi_b), .pipe_data_in(pdi_b),
    .pipe_valid_out(pvo_b), .pipe_data_out(pd_b[DEPTH-1]),
    .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .flush_req(flush_req),
    .flush_done(fd_b), .busy(busy_b), .err(err_b));

  // Fixed-latency pipe with its own synchronous reset.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < DEPTH; s++) begin
        pv_a[s] <= 1'b0; pd_a[s] <= '0; pv_b[s] <= 1'b0; pd_b[s] <= '0;
      end
    end else begin
      pv_a[0] <= pvi_a; pd_a[0] <= pdi_a; pv_b[0] <= pvi_b; pd_b[0] <= pdi_b;
      for (int s = 1; s < DEPTH; s++) begin
        pv_a[s] <= pv_a[s-1]; pd_a[s] <= pd_a[s-1];
        pv_b[s] <= pv_b[s-1]; pd_b[s] <= pd_b[s-1];
      end
    end
  end

  assign pvo_a = pv_a[DEPTH-1] | inject;
  assign pvo_b = pv_b[DEPTH-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb_on && reset_n) begin
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        sb_t e;
        e = sbq.pop_front();
        check("sb rsp_valid", rsp_valid_a, e.rsp);
        check("sb rsp_data", rsp_data_a, e.data);
      end else if (rsp_valid_a != '0) begin
        check("sb unexpected rsp", rsp_valid_a, 0);
      end
    end
  end

  task automatic do_reset();
    if (sb_on) check("sb drained", sbq.size(), 0);
    reset_n   = 1'b0;
    req       = '0;
    flush_req = 1'b0;
    inject    = 1'b0;
    sbq.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic add(input bit rst, input logic [NREQ-1:0] r, input logic [NREQ*W-1:0] d,
                     input bit fl, input logic [NREQ-1:0] g, input logic [W-1:0] pd,
                     input bit b, input bit fd);
    vecs.push_back('{rst, r, d, fl, g, pd, b, fd});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NREQ*W-1:0] dd, dz;
    dd = 32'h44332211;
    dz = 32'h005A0000;

    // Round robin from reset, then requests drop and the pipe empties.
    add(1, 4'hF, dd, 0, 4'h0, 8'h00, 0, 0);
    repeat (2) begin
      add(0, 4'hF, dd, 0, 4'h1, 8'h11, 1, 0);
      add(0, 4'hF, dd, 0, 4'h2, 8'h22, 1, 0);
      add(0, 4'hF, dd, 0, 4'h4, 8'h33, 1, 0);
      add(0, 4'hF, dd, 0, 4'h8, 8'h44, 1, 0);
    end
    repeat (5) add(0, 4'h0, dd, 0, 4'h0, 8'h00, 1, 0);
    add(0, 4'h0, dd, 0, 4'h0, 8'h00, 0, 0);
    // Single requester 2.
    add(1, 4'h4, dz, 0, 4'h0, 8'h00, 0, 0);
    add(0, 4'h4, dz, 0, 4'h4, 8'h5A, 1, 0);
    repeat (5) add(0, 4'h0, dz, 0, 4'h0, 8'h00, 1, 0);
    add(0, 4'h0, dz, 0, 4'h0, 8'h00, 0, 0);
    // Drain with three in flight.
    add(1, 4'h7, dd, 0, 4'h0, 8'h00, 0, 0);
    add(0, 4'h7, dd, 0, 4'h1, 8'h11, 1, 0);
    add(0, 4'h7, dd, 0, 4'h2, 8'h22, 1, 0);
    add(0, 4'h7, dd, 0, 4'h4, 8'h33, 1, 0);
    add(0, 4'h7, dd, 1, 4'h0, 8'h00, 1, 0);
    repeat (3) add(0, 4'h0, dd, 0, 4'h0, 8'h00, 1, 0);
    add(0, 4'h0, dd, 0, 4'h0, 8'h00, 0, 1);
    add(0, 4'h0, dd, 0, 4'h0, 8'h00, 0, 0);
    // Flush from empty IDLE; a second flush while draining is ignored.
    add(1, 4'h0, dd, 1, 4'h0, 8'h00, 0, 0);
    add(0, 4'h0, dd, 1, 4'h0, 8'h00, 1, 0);
    add(0, 4'h0, dd, 0, 4'h0, 8'h00, 0, 1);
    add(0, 4'h0, dd, 0, 4'h0, 8'h00, 0, 0);

    // Outputs held at zero during reset even with requests present.
    req = 4'hF;
    #1 reset_n = 1'b0;
    #1;
    check("rst gnt", gnt_a, 0);
    check("rst pipe_valid_in", pvi_a, 0);
    check("rst pipe_data_in", pdi_a, 0);
    check("rst rsp_valid", rsp_valid_a, 0);
    check("rst busy", busy_a, 0);
    check("rst err", err_a, 0);
    check("rst flush_done", fd_a, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      vec_t v;
      v = vecs[k];
      if (v.rst) do_reset();
      else begin
        @(posedge clk);
        #1;
      end
      req       = v.req;
      req_data  = v.data;
      flush_req = v.flush;
      @(negedge clk);
      check($sformatf("v%0d gnt", k), gnt_a, v.gnt);
      check($sformatf("v%0d pipe_valid_in", k), pvi_a, |v.gnt);
      check($sformatf("v%0d pipe_data_in", k), pdi_a, v.pdata);
      check($sformatf("v%0d busy", k), busy_a, v.busy);
      check($sformatf("v%0d flush_done", k), fd_a, v.fd);
      check($sformatf("v%0d err", k), err_a, 0);
      for (int i = 0; i < NREQ; i++)
        if (v.gnt[i]) sbq.push_back('{cyc + DEPTH, v.gnt, v.data[i*W +: W]});
    end

    // Credit limit on the MAX_OUT=1 instance: one issue per pipe round trip.
    do_reset();
    sb_on = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      req      = 4'h1;
      req_data = 32'h000000C3;
      @(negedge clk);
      check($sformatf("credit c%0d gnt", c), gnt_b, (c >= 1 && (c - 1) % 4 == 0) ? 1 : 0);
      check($sformatf("credit c%0d rsp", c), rsp_valid_b, (c >= 5 && (c - 1) % 4 == 0) ? 1 : 0);
      check($sformatf("credit c%0d cnt<=1", c), dut_b.outstanding[0] <= 1, 1);
    end
    check("credit err", err_b, 0);

    // Protocol error: valid from the pipe with no matching tag.
    do_reset();
    inject = 1'b1;
    @(negedge clk);
    check("perr before edge", err_a, 0);
    @(posedge clk);
    #1 inject = 1'b0;
    @(negedge clk);
    check("perr set", err_a, 1);
    repeat (3) @(negedge clk);
    check("perr sticky", err_a, 1);
    #1 reset_n = 1'b0;
    #1 check("perr cleared by reset", err_a, 0);

    // Asynchronous reset with four transactions in flight.
    do_reset();
    req      = 4'hF;
    req_data = 32'h44332211;
    repeat (5) @(posedge clk);
    #1 req = 4'h0;
    check("async busy before", busy_a, 1);
    #2;
    reset_n = 1'b0;
    req     = 4'hF;
    #1;
    check("async gnt", gnt_a, 0);
    check("async pipe_valid_in", pvi_a, 0);
    check("async pipe_data_in", pdi_a, 0);
    check("async rsp_valid", rsp_valid_a, 0);
    check("async busy", busy_a, 0);
    @(posedge clk);
    #3;
    req     = 4'h0;
    reset_n = 1'b1;
    sb_on   = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("async post c%0d rsp", c), rsp_valid_a, 0);
      check($sformatf("async post c%0d err", c), err_a, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
